// File: rtl/ahb_master_arbiter_pkg.sv
// Package with the shared AHB-Lite types and constants for the master arbiter.
// Contents: htrans_e and hresp_e encodings, HSIZE constants, and a one-hot helper.
// The optional lock feature is enabled by the macro AHB_ARB_LOCK_EN. It is checked in the
// interface and top files.
package ahb_master_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        OKAY  = 2'b00,
        ERROR = 2'b01
    } hresp_e;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    // One-hot decode of a master index. The result is sized for the maximum of 4 masters.
    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        logic [3:0] r;
        r = '0;
        r[idx] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/ahb_master_arbiter_if.sv
// Interface that bundles every bus signal between the masters, the arbiter and the slave.
// It has two modports:
//   master - the arbiter's view. It reads the per-master requests and controls and the
//            slave response. It drives the grant, the muxed slave-side signals and the
//            broadcast response.
//   slave  - the surrounding system's view (masters plus slave model). It has the
//            opposite directions.
// Per-master signals: HBUSREQ, M_HADDR, M_HTRANS, M_HWRITE, M_HSIZE, M_HWDATA, M_WSTRB.
// Arbiter signals:    HGRANT, HMASTER.
// Slave side:         HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, WSTRB.
// Response:           HREADYOUT_S and HRESP_S come in from the slave.
//                     HREADY and HRESP are the broadcast copies.
// When AHB_ARB_LOCK_EN is defined, the interface also carries M_HMASTLOCK and HMASTLOCK.
interface ahb_master_arbiter_if #(
    parameter int unsigned NUM_MASTERS = 2
);
    logic [NUM_MASTERS-1:0]       HBUSREQ;
    logic [NUM_MASTERS-1:0]       HGRANT;
    logic [1:0]                   HMASTER;
    logic [NUM_MASTERS-1:0][31:0] M_HADDR;
    logic [NUM_MASTERS-1:0][1:0]  M_HTRANS;
    logic [NUM_MASTERS-1:0]       M_HWRITE;
    logic [NUM_MASTERS-1:0][2:0]  M_HSIZE;
    logic [NUM_MASTERS-1:0][31:0] M_HWDATA;
    logic [NUM_MASTERS-1:0][3:0]  M_WSTRB;
    logic                         HSEL;
    logic [31:0]                  HADDR;
    logic [1:0]                   HTRANS;
    logic                         HWRITE;
    logic [2:0]                   HSIZE;
    logic [31:0]                  HWDATA;
    logic [3:0]                   WSTRB;
    logic                         HREADYOUT_S;
    logic [1:0]                   HRESP_S;
    logic                         HREADY;
    logic [1:0]                   HRESP;
`ifdef AHB_ARB_LOCK_EN
    logic [NUM_MASTERS-1:0]       M_HMASTLOCK;
    logic                         HMASTLOCK;
`endif

    modport master (
`ifdef AHB_ARB_LOCK_EN
        input  M_HMASTLOCK,
        output HMASTLOCK,
`endif
        input  HBUSREQ, M_HADDR, M_HTRANS, M_HWRITE, M_HSIZE, M_HWDATA, M_WSTRB,
        input  HREADYOUT_S, HRESP_S,
        output HGRANT, HMASTER, HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, WSTRB,
        output HREADY, HRESP
    );

    modport slave (
`ifdef AHB_ARB_LOCK_EN
        output M_HMASTLOCK,
        input  HMASTLOCK,
`endif
        output HBUSREQ, M_HADDR, M_HTRANS, M_HWRITE, M_HSIZE, M_HWDATA, M_WSTRB,
        output HREADYOUT_S, HRESP_S,
        input  HGRANT, HMASTER, HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, WSTRB,
        input  HREADY, HRESP
    );

endinterface

// File: rtl/ahb_master_arbiter_rr_picker.sv
// dmac_rr_picker: combinational round-robin picker.
//   req   - per-master request vector
//   ptr   - index where the search starts. The search wraps modulo NUM_MASTERS.
//   grant - one-hot pick. It is all-zero when nobody requests.
//   valid - high when some request was found
module dmac_rr_picker #(
    parameter int unsigned NUM_MASTERS = 2
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [1:0]             ptr,
    output logic [NUM_MASTERS-1:0] grant,
    output logic                   valid
);

    always_comb begin
        grant = '0;
        valid = 1'b0;
        // The outer loop walks the priority order ptr, ptr+1, ... The inner loop finds
        // the master that sits at that position.
        for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
            for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
                if (!valid && req[i] && (i == (32'(ptr) + k) % NUM_MASTERS)) begin
                    grant[i] = 1'b1;
                    valid    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ahb_master_arbiter.sv
// ahb_master_arbiter: shares one AHB-Lite slave port between NUM_MASTERS masters.
// It uses round-robin arbitration with a MAX_HOLD limit on consecutive address-phase
// ownership.
// Ports:
//   HCLK   - clock
//   HRESET - asynchronous reset, active-high
//   bus    - ahb_master_arbiter_if.master. It carries the requests, grant, the
//            address/control mux (by address-phase owner), the write-data mux (by
//            data-phase owner), and the broadcast slave response.
// Optional feature: when AHB_ARB_LOCK_EN is defined, the arbiter has locked transfers.
//   A locked owner is never preempted.
//   The lock stays in force for one extra HREADY cycle after M_HMASTLOCK drops.
module ahb_master_arbiter
    import ahb_master_arbiter_pkg::*;
#(
    parameter int unsigned NUM_MASTERS    = 2,
    parameter int unsigned MAX_HOLD       = 16,
    parameter int unsigned DEFAULT_MASTER = 0
) (
    input logic                  HCLK,
    input logic                  HRESET,
    ahb_master_arbiter_if.master bus
);

    localparam int unsigned      HOLD_W   = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD - 1);
    localparam logic [1:0]       DEF_IDX  = 2'(DEFAULT_MASTER);

    logic [1:0]             addr_owner, data_owner, next_owner;
    logic [HOLD_W-1:0]      hold_cnt, next_hold;
    logic [NUM_MASTERS-1:0] owner_oh, data_oh;
    logic                   owner_req, others_req, mid_burst, below_limit;
    logic                   keep, lock_active, ready;
    logic [1:0]             owner_trans;
    logic [1:0]             rr_start, pick_idx;
    logic [NUM_MASTERS-1:0] pick_grant;
    logic                   pick_valid;
`ifdef AHB_ARB_LOCK_EN
    logic                   lock_q, owner_lock;
`endif

    assign ready = bus.HREADYOUT_S;

    always_comb begin
        owner_oh = onehot4(addr_owner)[NUM_MASTERS-1:0];
        data_oh  = onehot4(data_owner)[NUM_MASTERS-1:0];
    end

    // Address/control follow the address-phase owner.
    // Write data and strobes follow the data-phase owner.
    always_comb begin
        owner_req   = 1'b0;
        owner_trans = IDLE;
        bus.HADDR   = '0;
        bus.HWRITE  = 1'b0;
        bus.HSIZE   = '0;
        bus.HWDATA  = '0;
        bus.WSTRB   = '0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            if (owner_oh[i]) begin
                owner_req   = bus.HBUSREQ[i];
                owner_trans = bus.M_HTRANS[i];
                bus.HADDR   = bus.M_HADDR[i];
                bus.HWRITE  = bus.M_HWRITE[i];
                bus.HSIZE   = bus.M_HSIZE[i];
            end
            if (data_oh[i]) begin
                bus.HWDATA = bus.M_HWDATA[i];
                bus.WSTRB  = bus.M_WSTRB[i];
            end
        end
    end

`ifdef AHB_ARB_LOCK_EN
    always_comb begin
        owner_lock = 1'b0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            if (owner_oh[i]) owner_lock = bus.M_HMASTLOCK[i];
        end
    end
    assign lock_active   = owner_lock | lock_q;
    assign bus.HMASTLOCK = owner_lock;
`else
    assign lock_active = 1'b0;
`endif

    assign others_req  = |(bus.HBUSREQ & ~owner_oh);
    assign mid_burst   = (owner_trans == SEQ) || (owner_trans == BUSY);
    assign below_limit = hold_cnt < HOLD_MAX;
    assign rr_start    = 2'((32'(addr_owner) + 32'd1) % NUM_MASTERS);

    dmac_rr_picker #(
        .NUM_MASTERS(NUM_MASTERS)
    ) u_picker (
        .req   (bus.HBUSREQ),
        .ptr   (rr_start),
        .grant (pick_grant),
        .valid (pick_valid)
    );

    always_comb begin
        pick_idx = DEF_IDX;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            if (pick_grant[i]) pick_idx = 2'(i);
        end
    end

    // When the owner keeps the bus, the picker result is ignored.
    // When the owner gives the bus up, the picker can never select the owner again:
    // either the owner has stopped requesting, or another requester sits earlier in
    // the rotation.
    always_comb begin
        keep       = lock_active || (owner_req && (mid_burst || below_limit || !others_req));
        next_owner = keep ? addr_owner : (pick_valid ? pick_idx : DEF_IDX);
        next_hold  = '0;
        if (keep && others_req) begin
            next_hold = below_limit ? hold_cnt + 1'b1 : hold_cnt;
        end
    end

    // All state advances only when HREADY is high.
    // Wait states and the first ERROR cycle therefore freeze the arbitration.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            addr_owner <= DEF_IDX;
            data_owner <= DEF_IDX;
            hold_cnt   <= '0;
`ifdef AHB_ARB_LOCK_EN
            lock_q     <= 1'b0;
`endif
        end else if (ready) begin
            data_owner <= addr_owner;
            addr_owner <= next_owner;
            hold_cnt   <= next_hold;
`ifdef AHB_ARB_LOCK_EN
            lock_q     <= owner_lock;
`endif
        end
    end

    assign bus.HGRANT  = owner_oh;
    assign bus.HMASTER = addr_owner;
    assign bus.HTRANS  = HRESET ? IDLE : owner_trans;
    assign bus.HSEL    = bus.HTRANS[1];
    assign bus.HREADY  = ready;
    assign bus.HRESP   = bus.HRESP_S;

endmodule
